// File: rtl/arpas_pkg.sv
// Shared ARPAS receive-path types and default sizing constants.
package arpas_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      MEASURE = 2'd2,
      DONE    = 2'd3
   } state_e;

   localparam int ARPAS_CNT_W    = 16;
   localparam int ARPAS_WINDOW   = 1000;
   localparam int ARPAS_MAX_WAIT = 50000;

endpackage

// File: rtl/arpas_sync_edge.sv
// Two-flop synchronizer for an asynchronous comparator input, plus a
// rising-edge detector on the synchronized level.
module arpas_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic s1_q, s2_q, s3_q;
   logic s1_d, s2_d, s3_d;

   // Shift chain: s1/s2 resolve metastability, s3 remembers the previous level.
   always_comb begin
      s1_d = d;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   // Chain registers, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/arpas_tdoa.sv
// Inter-channel time-difference-of-arrival measurement for the ARPAS
// receive path. Result handshake: valid rises with delta/side/ovf stable and
// stays high until a cycle with ack=1 is sampled; valid drops on the next
// cycle. ack while valid=0 is ignored. Result fields hold after ack.
module arpas_tdoa
   import arpas_pkg::*;
#(
   parameter int CNT_W    = ARPAS_CNT_W,
   parameter int WINDOW   = ARPAS_WINDOW,
   parameter int MAX_WAIT = ARPAS_MAX_WAIT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             left,
   input  logic             right,
   input  logic             first,
   input  logic             start,
   input  logic             ack,
   output logic             busy,
   output logic             valid,
   output logic [CNT_W-1:0] delta,
   output logic             side,
   output logic             ovf,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] WIN_C     = CNT_W'(WINDOW);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   logic l_rise, r_rise;
   logic first_s1_q, first_s2_q;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0] dly_q, dly_d;
   logic [CNT_W-1:0] delta_q, delta_d;
   logic             lead_q, lead_d;
   logic             side_q, side_d;
   logic             ovf_q, ovf_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;

   arpas_sync_edge u_left  (.clk(clk), .rst_n(rst_n), .d(left),  .rise(l_rise));
   arpas_sync_edge u_right (.clk(clk), .rst_n(rst_n), .d(right), .rise(r_rise));

   // The order flag only needs a level synchronizer; it is a tie-break input.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         first_s1_q <= 1'b0;
         first_s2_q <= 1'b0;
      end else begin
         first_s1_q <= first;
         first_s2_q <= first_s1_q;
      end
   end

   // Next-state and result logic; lead_q tracks the first channel internally
   // so the published side only changes when a new result is produced.
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      dly_d     = dly_q;
      delta_d   = delta_q;
      lead_d    = lead_q;
      side_d    = side_q;
      ovf_d     = ovf_q;
      valid_d   = valid_q;
      timeout_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ARMED;
               wait_d  = '0;
            end
         end
         ARMED: begin
            wait_d = (wait_q == '1) ? wait_q : wait_q + ONE_C;
            if (l_rise && r_rise) begin
               state_d = DONE;
               delta_d = '0;
               side_d  = first_s2_q;
               ovf_d   = 1'b0;
               valid_d = 1'b1;
            end else if (l_rise || r_rise) begin
               state_d = MEASURE;
               lead_d  = l_rise;
               dly_d   = ONE_C;
            end else if (wait_q == WAIT_LAST) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
            end
         end
         MEASURE: begin
            dly_d = (dly_q == '1) ? dly_q : dly_q + ONE_C;
            if (dly_q == WIN_C) begin
               state_d = DONE;
               delta_d = WIN_C;
               side_d  = lead_q;
               ovf_d   = 1'b1;
               valid_d = 1'b1;
            end else if (lead_q ? r_rise : l_rise) begin
               state_d = DONE;
               delta_d = dly_q;
               side_d  = lead_q;
               ovf_d   = 1'b0;
               valid_d = 1'b1;
            end
         end
         DONE: begin
            if (ack && valid_q) begin
               state_d = IDLE;
               valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and result registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         wait_q    <= '0;
         dly_q     <= '0;
         delta_q   <= '0;
         lead_q    <= 1'b0;
         side_q    <= 1'b0;
         ovf_q     <= 1'b0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         dly_q     <= dly_d;
         delta_q   <= delta_d;
         lead_q    <= lead_d;
         side_q    <= side_d;
         ovf_q     <= ovf_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign valid   = valid_q;
   assign delta   = delta_q;
   assign side    = side_q;
   assign ovf     = ovf_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_arpas_tdoa.sv
// Directed bench for arpas_tdoa with an expected-result queue.
module tb_arpas_tdoa;

   localparam int CNT_W    = 16;
   localparam int WINDOW   = 1000;
   localparam int MAX_WAIT = 5000;
   localparam int RW       = CNT_W + 2;

   logic             clk = 1'b0;
   logic             rst_n, left, right, first, start, ack;
   logic             busy, valid, side, ovf, timeout;
   logic [CNT_W-1:0] delta;

   logic [RW-1:0] exp_q[$];
   int chk_cnt  = 0;
   int pass_cnt = 0;
   int fail_cnt = 0;

   arpas_tdoa #(.CNT_W(CNT_W), .WINDOW(WINDOW), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst_n(rst_n), .left(left), .right(right), .first(first),
      .start(start), .ack(ack), .busy(busy), .valid(valid), .delta(delta),
      .side(side), .ovf(ovf), .timeout(timeout)
   );

   // Clock.
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic o, input logic s, input int d);
      logic [CNT_W-1:0] dv;
      dv = CNT_W'(d);
      exp_q.push_back({o, s, dv});
   endtask

   task automatic arm();
      start = 1'b1;
      step();
      start = 1'b0;
      check("busy_after_start", busy, 1);
   endtask

   task automatic wait_valid(input int budget, output int n);
      logic [RW-1:0] e;
      n = 0;
      while (valid !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      check("valid_seen", valid, 1);
      if (valid === 1'b1) begin
         if (exp_q.size() == 0) check("result_unexpected", 1, 0);
         else begin
            e = exp_q.pop_front();
            check("result", {ovf, side, delta}, e);
         end
      end
   endtask

   task automatic do_ack();
      ack = 1'b1;
      step();
      ack = 1'b0;
      check("valid_after_ack", valid, 0);
      check("busy_after_ack", busy, 0);
   endtask

   task automatic clear_inputs();
      left  = 1'b0;
      right = 1'b0;
      repeat (4) step();
   endtask

   // Directed sequence.
   initial begin
      int n;
      int tcnt;
      rst_n = 1'b0; left = 1'b0; right = 1'b0; first = 1'b0; start = 1'b0; ack = 1'b0;
      repeat (3) step();
      check("rst_outputs", {busy, valid, side, ovf, timeout, delta}, 0);
      rst_n = 1'b1;
      step();

      // Left then right, 37 cycles apart.
      arm();
      repeat (10) step();
      left = 1'b1;
      repeat (37) step();
      right = 1'b1;
      push_exp(1'b0, 1'b1, 37);
      wait_valid(20, n);
      check("edge_to_valid_latency", n, 3);
      repeat (5) step();
      check("valid_held", {valid, delta}, {1'b1, 16'd37});
      do_ack();
      check("delta_hold_after_ack", delta, 37);
      clear_inputs();

      // Right then left 5 cycles later, with a repeat right pulse between.
      arm();
      right = 1'b1;
      repeat (2) step();
      right = 1'b0;
      step();
      right = 1'b1;
      repeat (2) step();
      left = 1'b1;
      push_exp(1'b0, 1'b0, 5);
      wait_valid(20, n);
      do_ack();
      clear_inputs();

      // Simultaneous edges, tie broken by first.
      for (int f = 0; f < 2; f++) begin
         first = f[0];
         repeat (3) step();
         arm();
         repeat (3) step();
         left = 1'b1;
         right = 1'b1;
         push_exp(1'b0, f[0], 0);
         wait_valid(20, n);
         do_ack();
         clear_inputs();
      end

      // Overflow: only left rises.
      arm();
      left = 1'b1;
      push_exp(1'b1, 1'b1, WINDOW);
      wait_valid(WINDOW + 50, n);
      check("ovf_latency", n, WINDOW + 3);
      do_ack();
      clear_inputs();

      // Timeout with no echoes.
      arm();
      n = 0;
      while (timeout !== 1'b1 && n < MAX_WAIT + 50) begin
         check_no_valid: assert (valid !== 1'b1) else begin end
         step();
         n++;
      end
      check("timeout_cycle", n, MAX_WAIT);
      check("timeout_state", {timeout, valid, busy}, 3'b100);
      step();
      check("timeout_single", timeout, 0);

      // Reset during MEASURE aborts everything.
      arm();
      left = 1'b1;
      repeat (8) step();
      check("in_measure", busy, 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("rst_mid_outputs", {busy, valid, side, ovf, timeout, delta}, 0);
      tcnt = 0;
      repeat (30) begin
         step();
         if (timeout === 1'b1 || valid === 1'b1 || busy === 1'b1) tcnt++;
      end
      check("idle_after_rst", tcnt, 0);
      clear_inputs();

      // start while a result is pending is ignored; start with ack is dropped.
      arm();
      left = 1'b1;
      repeat (3) step();
      right = 1'b1;
      push_exp(1'b0, 1'b1, 3);
      wait_valid(20, n);
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (2) step();
      check("pending_unchanged", {valid, busy, side, delta}, {1'b1, 1'b1, 1'b1, 16'd3});
      start = 1'b1;
      ack = 1'b1;
      step();
      start = 1'b0;
      ack = 1'b0;
      check("start_with_ack_valid", valid, 0);
      step();
      check("start_with_ack_dropped", busy, 0);
      clear_inputs();

      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/arpas_tdoa.md
Name: arpas_tdoa

Overview:
- Downstream consumer of the two-channel arrival-order detector in the ARPAS SONAR receive path.
- Takes the same left/right echo comparator pulses, plus that stage's `first` flag, and measures the inter-channel arrival delay in clock cycles.
- Produces a signed-magnitude measurement with a valid/ack handshake for the beam-steering logic.
- Arms on each transmit ping and times out if no echo returns.

Parameters:
- CNT_W, 16, width of delay and wait counters.
- WINDOW, 1000, maximum measurable inter-channel delay in cycles; at or beyond this the result saturates.
- MAX_WAIT, 50000, cycles to wait in ARMED for any echo before timeout; must be < 2^CNT_W.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- left  in  1  asynchronous left transducer echo comparator.
- right  in  1  asynchronous right transducer echo comparator.
- first  in  1  arrival-order flag from the upstream order detector (1 = left first); used only for tie-break.
- start  in  1  one-cycle ping-fired pulse; arms a measurement.
- ack  in  1  consumer has taken the result.
- busy  out  1  high in any state other than IDLE.
- valid  out  1  result available; held until ack.
- delta  out  CNT_W  arrival delay magnitude in cycles.
- side  out  1  1 = left arrived first, 0 = right first.
- ovf  out  1  delay reached WINDOW; delta = WINDOW.
- timeout  out  1  one-cycle pulse: no echo within MAX_WAIT.

Behaviour:
- Reset: synchronous and active-low. All outputs are 0, state is IDLE, counters are 0 and synchronizers are cleared. Reset mid-operation aborts with no result or timeout pulse.
- Input conditioning:
  - left, right and first each pass through a 2-flop synchronizer.
  - Rising edges are detected on synced left/right (sync2 & ~sync3).
  - The added latency is identical on both channels, so delta is unaffected.
- IDLE:
  - start=1 → ARMED next cycle; wait counter cleared.
  - Edges are ignored in IDLE.
- ARMED: wait counter increments each cycle. The first matching row wins:
  - Both edges in the same cycle → DONE with delta=0 and side=synced first.
  - Exactly one edge → MEASURE; side = 1 if the left edge, 0 if the right edge; delay counter = 1.
  - Wait counter reaches MAX_WAIT-1 with no edge → timeout=1 for one cycle, then IDLE.
- MEASURE:
  - Delay counter increments each cycle.
  - Edge on the opposite channel → DONE; delta = counter value at that cycle.
  - Repeat edges on the first channel are ignored.
  - Counter reaches WINDOW → DONE with delta=WINDOW and ovf=1.
  - Delay is therefore the number of clk cycles between the two synced edges (1 = adjacent cycles).
- DONE:
  - valid=1 with delta, side and ovf stable.
  - ack=1 while valid=1 → valid=0 and IDLE on the next cycle.
  - Outputs hold their last values after ack until the next result.
- Rules in any non-IDLE state:
  - start is ignored, including while valid is pending. There is no queuing.
  - ack while valid=0 has no effect.
- Simultaneous start and ack in DONE: ack is taken and start is dropped; the bench must re-pulse start.
- Arithmetic:
  - Counters are unsigned CNT_W, saturating, and never wrap.
  - WINDOW and MAX_WAIT are compared with equality against the counter.
- Latency: from start high to busy high is 1 cycle. From the second-channel raw edge to valid is 3 cycles (2 sync, 1 register).

Decomposition:
- Shared package `arpas_pkg`:
  - state enum {IDLE, ARMED, MEASURE, DONE};
  - default CNT_W, WINDOW and MAX_WAIT constants, reused by the beam-steering block.
- Sub-module `arpas_sync_edge`: 2-flop synchronizer plus rising-edge detector. Instantiated for left and right; first uses the synchronizer path only.

Test Plan:
- Left then right: start, left rises 10 cycles after arming, right 37 cycles after left → valid with delta=37, side=1, ovf=0; valid held until ack, drops the cycle after ack.
- Right then left: right rises, then left 5 cycles later → delta=5, side=0; a second right pulse between them does not change the result.
- Tie-break: left and right rise in the same cycle with first=0 → delta=0, side=0; repeat with first=1 → side=1.
- Overflow: left rises, right never rises → after WINDOW=1000 cycles valid=1, delta=1000, ovf=1, side=1.
- Timeout: start with no echoes → timeout is a single-cycle pulse at MAX_WAIT cycles after arming; valid stays 0 and busy falls.
- Reset and ignore rules:
  - rst_n low for one cycle during MEASURE → all outputs 0, IDLE, no timeout.
  - start while valid is pending → ignored; the result is unchanged until ack.
